// File: rtl/axis_video_frame_monitor.sv
// axis_video_frame_monitor
// AXI4-Stream video pass-through with a 2-entry skid buffer and a line/frame
// geometry monitor (pixels per line, lines per frame, SOF count, sticky
// framing error flags).
//
// Optional feature (compile-time macro AXIS_VIDEO_MON_SOF_SYNC_EN):
//   when defined, every input beat after reset is accepted and dropped until
//   the first tuser (SOF) beat, which is forwarded and starts monitoring.
//   When undefined, all beats are forwarded and counted from reset.
//
// Handshake: a beat transfers on a port when tvalid & tready & aclken are all
// high on a rising aclk edge; a master holds tvalid and its payload stable
// until that happens, and tready never depends combinationally on tvalid.

module axis_video_frame_monitor #(
  parameter int DATA_WIDTH = 8,
  parameter int HSIZE      = 640,
  parameter int VSIZE      = 480,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  aclken,
  // slave (input) video stream
  input  logic [DATA_WIDTH-1:0] s_axis_video_tdata,
  input  logic                  s_axis_video_tvalid,
  output logic                  s_axis_video_tready,
  input  logic                  s_axis_video_tuser,
  input  logic                  s_axis_video_tlast,
  // master (output) video stream
  output logic [DATA_WIDTH-1:0] m_axis_video_tdata,
  output logic                  m_axis_video_tvalid,
  input  logic                  m_axis_video_tready,
  output logic                  m_axis_video_tuser,
  output logic                  m_axis_video_tlast,
  // measurements
  output logic [CNT_WIDTH-1:0]  line_len,
  output logic [CNT_WIDTH-1:0]  frame_lines,
  output logic [15:0]           frame_cnt,
  // sticky error flags
  output logic                  err_eol_early,
  output logic                  err_eol_late,
  output logic                  err_sof_early,
  output logic                  err_sof_late,
  input  logic                  err_clr
);

  // payload word layout: {tuser, tlast, tdata}
  localparam int PW = DATA_WIDTH + 2;

  localparam logic [CNT_WIDTH-1:0] PIX_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] H_LAST  = CNT_WIDTH'(HSIZE - 1);
  localparam logic [CNT_WIDTH-1:0] V_SIZE  = CNT_WIDTH'(VSIZE);

  // error flag bit positions inside err_q
  localparam int E_EOL_EARLY = 3;
  localparam int E_EOL_LATE  = 2;
  localparam int E_SOF_EARLY = 1;
  localparam int E_SOF_LATE  = 0;

  // skid buffer state
  logic [PW-1:0]        out_q, out_d;
  logic                 out_vld_q, out_vld_d;
  logic [PW-1:0]        skid_q, skid_d;
  logic                 skid_vld_q, skid_vld_d;
  logic                 s_rdy_q;

  // monitor state
  logic [CNT_WIDTH-1:0] pix_q, pix_d;
  logic [CNT_WIDTH-1:0] line_q, line_d;
  logic [CNT_WIDTH-1:0] line_len_q, line_len_d;
  logic [CNT_WIDTH-1:0] frame_lines_q, frame_lines_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [3:0]           err_q, err_d;
  logic                 first_q, first_d;

  logic [PW-1:0]        in_word;
  logic                 in_beat;
  logic                 out_beat;
  logic                 drop;
  logic                 fwd;
  logic [3:0]           err_set;
  logic [CNT_WIDTH-1:0] line_base;

  assign in_word  = {s_axis_video_tuser, s_axis_video_tlast, s_axis_video_tdata};
  assign in_beat  = s_axis_video_tvalid & s_rdy_q & aclken;
  assign out_beat = out_vld_q & m_axis_video_tready & aclken;

`ifdef AXIS_VIDEO_MON_SOF_SYNC_EN
  // before the first SOF since reset, non-SOF beats are swallowed
  assign drop = first_q & ~s_axis_video_tuser;
`else
  assign drop = 1'b0;
`endif

  // beats that are forwarded downstream and seen by the monitor
  assign fwd = in_beat & ~drop;

  // skid buffer next state: the output register refills from the skid entry
  // first (to preserve order), otherwise straight from the input
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (aclken) begin
      if (out_beat || !out_vld_q) begin
        if (skid_vld_q) begin
          out_d      = skid_q;
          out_vld_d  = 1'b1;
          skid_vld_d = 1'b0;
        end else begin
          out_vld_d = fwd;
          if (fwd) out_d = in_word;
        end
      end else if (fwd) begin
        // output stalled: park the accepted beat; tready drops next cycle
        skid_d     = in_word;
        skid_vld_d = 1'b1;
      end
    end
  end

  // monitor next state: pixel/line counters, measurements and error events
  always_comb begin
    pix_d         = pix_q;
    line_d        = line_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    frame_cnt_d   = frame_cnt_q;
    first_d       = first_q;
    err_set       = 4'b0000;
    line_base     = s_axis_video_tuser ? '0 : line_q;
    if (fwd) begin
      if (s_axis_video_tlast) begin
        pix_d      = '0;
        line_len_d = pix_q + 1'b1;
      end else if (pix_q != PIX_MAX) begin
        pix_d = pix_q + 1'b1;
      end
      // SOF clears the line count, then the same beat's EOL still counts
      line_d = line_base + CNT_WIDTH'(s_axis_video_tlast);
      err_set[E_EOL_EARLY] = s_axis_video_tlast && (pix_q < H_LAST);
      err_set[E_EOL_LATE]  = !s_axis_video_tlast && (pix_q >= H_LAST);
      err_set[E_SOF_EARLY] = s_axis_video_tuser && !first_q &&
                             ((line_q != V_SIZE) || (pix_q != '0));
      err_set[E_SOF_LATE]  = !s_axis_video_tuser && (pix_q == '0) &&
                             (line_q == V_SIZE);
      if (s_axis_video_tuser) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        first_d     = 1'b0;
        if (!first_q) frame_lines_d = line_q;
      end
    end
  end

  // sticky error flags: a set event in the same cycle wins over err_clr
  always_comb begin
    err_d = err_q;
    if (aclken) err_d = err_set | (err_q & ~{4{err_clr}});
  end

  // state registers; tready tracks "skid entry empty" one cycle behind
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_q         <= '0;
      out_vld_q     <= 1'b0;
      skid_q        <= '0;
      skid_vld_q    <= 1'b0;
      s_rdy_q       <= 1'b0;
      pix_q         <= '0;
      line_q        <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      frame_cnt_q   <= '0;
      err_q         <= '0;
      first_q       <= 1'b1;
    end else begin
      out_q         <= out_d;
      out_vld_q     <= out_vld_d;
      skid_q        <= skid_d;
      skid_vld_q    <= skid_vld_d;
      s_rdy_q       <= ~skid_vld_d;
      pix_q         <= pix_d;
      line_q        <= line_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      frame_cnt_q   <= frame_cnt_d;
      err_q         <= err_d;
      first_q       <= first_d;
    end
  end

  assign s_axis_video_tready = s_rdy_q;
  assign m_axis_video_tvalid = out_vld_q;
  assign m_axis_video_tuser  = out_q[PW-1];
  assign m_axis_video_tlast  = out_q[PW-2];
  assign m_axis_video_tdata  = out_q[DATA_WIDTH-1:0];
  assign line_len            = line_len_q;
  assign frame_lines         = frame_lines_q;
  assign frame_cnt           = frame_cnt_q;
  assign err_eol_early       = err_q[E_EOL_EARLY];
  assign err_eol_late        = err_q[E_EOL_LATE];
  assign err_sof_early       = err_q[E_SOF_EARLY];
  assign err_sof_late        = err_q[E_SOF_LATE];

endmodule

// File: tb/tb_axis_video_frame_monitor.sv
// Testbench for axis_video_frame_monitor with a 4x2 frame geometry.
// Table-driven vectors for the pass-through and monitor behaviour, plus
// hand-written sequences for backpressure, mid-frame reset and SOF sync.

module tb_axis_video_frame_monitor;

  localparam int DW = 8;
  localparam int CW = 12;

  // ---------------- clock / reset ----------------
  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  logic aclken  = 1'b1;
  always #5 aclk = ~aclk;

  logic [DW-1:0] s_tdata  = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tuser  = 1'b0;
  logic          s_tlast  = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tuser;
  logic          m_tlast;
  logic [CW-1:0] line_len;
  logic [CW-1:0] frame_lines;
  logic [15:0]   frame_cnt;
  logic          e_eol_early, e_eol_late, e_sof_early, e_sof_late;
  logic          err_clr = 1'b0;

  axis_video_frame_monitor #(
    .DATA_WIDTH(DW), .HSIZE(4), .VSIZE(2), .CNT_WIDTH(CW)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .aclken             (aclken),
    .s_axis_video_tdata (s_tdata),
    .s_axis_video_tvalid(s_tvalid),
    .s_axis_video_tready(s_tready),
    .s_axis_video_tuser (s_tuser),
    .s_axis_video_tlast (s_tlast),
    .m_axis_video_tdata (m_tdata),
    .m_axis_video_tvalid(m_tvalid),
    .m_axis_video_tready(m_tready),
    .m_axis_video_tuser (m_tuser),
    .m_axis_video_tlast (m_tlast),
    .line_len           (line_len),
    .frame_lines        (frame_lines),
    .frame_cnt          (frame_cnt),
    .err_eol_early      (e_eol_early),
    .err_eol_late       (e_eol_late),
    .err_sof_early      (e_sof_early),
    .err_sof_late       (e_sof_late),
    .err_clr            (err_clr)
  );

  logic [3:0] errs;
  assign errs = {e_eol_early, e_eol_late, e_sof_early, e_sof_late};

  // ---------------- scoreboard / counters ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW+1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          v, u, l;
    logic [DW-1:0] d;
    logic          clr;
    logic          ev;
    logic [DW-1:0] ed;
    logic          eu, el;
    logic [CW-1:0] len, fl;
    logic [15:0]   fc;
    logic [3:0]    err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic v, u, l, input logic [DW-1:0] d, input logic clr,
                              input logic ev, input logic [DW-1:0] ed, input logic eu, el,
                              input logic [CW-1:0] len, fl, input logic [15:0] fc,
                              input logic [3:0] err);
    vec_t t;
    t.v = v; t.u = u; t.l = l; t.d = d; t.clr = clr;
    t.ev = ev; t.ed = ed; t.eu = eu; t.el = el;
    t.len = len; t.fl = fl; t.fc = fc; t.err = err;
    vecs.push_back(t);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, u, l, input logic [DW-1:0] d);
    s_tvalid = v; s_tuser = u; s_tlast = l; s_tdata = d;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    drive(0, 0, 0, '0);
    m_tready = 1'b1;
    err_clr  = 1'b0;
    aresetn  = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [DW+1:0] beat_word(input int idx);
    logic [DW-1:0] d;
    d = DW'(idx * 7 + 3);
    return {(idx % 8) == 0, (idx % 4) == 3, d};
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [63:0] act, req;
    int nxt, rcvd, pre_cnt, frm_cnt;
    bit acc_prev, stall_prev, in_acc, out_acc;
    logic [DW+2:0] prev_w;

    // ---- reset state ----
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("reset_state",
          {s_tready, m_tvalid, m_tdata, m_tuser, m_tlast, line_len, frame_lines, frame_cnt, errs},
          64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("tready_after_reset", {63'd0, s_tready}, 64'd1);

    // ---- table: two clean 4x2 frames, then error cases ----
    // v u l  d    clr  ev ed   eu el  len fl fc err{eol_early,eol_late,sof_early,sof_late}
    add(1,1,0,8'h01,0, 1,8'h01,1,0, 0,0,1,4'b0000);
    add(1,0,0,8'h02,0, 1,8'h02,0,0, 0,0,1,4'b0000);
    add(1,0,0,8'h03,0, 1,8'h03,0,0, 0,0,1,4'b0000);
    add(1,0,1,8'h04,0, 1,8'h04,0,1, 4,0,1,4'b0000);
    add(1,0,0,8'h05,0, 1,8'h05,0,0, 4,0,1,4'b0000);
    add(1,0,0,8'h06,0, 1,8'h06,0,0, 4,0,1,4'b0000);
    add(1,0,0,8'h07,0, 1,8'h07,0,0, 4,0,1,4'b0000);
    add(1,0,1,8'h08,0, 1,8'h08,0,1, 4,0,1,4'b0000);
    add(1,1,0,8'h09,0, 1,8'h09,1,0, 4,2,2,4'b0000);
    add(1,0,0,8'h0A,0, 1,8'h0A,0,0, 4,2,2,4'b0000);
    add(1,0,0,8'h0B,0, 1,8'h0B,0,0, 4,2,2,4'b0000);
    add(1,0,1,8'h0C,0, 1,8'h0C,0,1, 4,2,2,4'b0000);
    add(1,0,0,8'h0D,0, 1,8'h0D,0,0, 4,2,2,4'b0000);
    add(1,0,0,8'h0E,0, 1,8'h0E,0,0, 4,2,2,4'b0000);
    add(1,0,0,8'h0F,0, 1,8'h0F,0,0, 4,2,2,4'b0000);
    add(1,0,1,8'h10,0, 1,8'h10,0,1, 4,2,2,4'b0000);
    add(0,0,0,8'h00,0, 0,8'h00,0,0, 4,2,2,4'b0000);
    // short line: EOL on the 3rd pixel, then clear
    add(1,1,0,8'h11,0, 1,8'h11,1,0, 4,2,3,4'b0000);
    add(1,0,0,8'h12,0, 1,8'h12,0,0, 4,2,3,4'b0000);
    add(1,0,1,8'h13,0, 1,8'h13,0,1, 3,2,3,4'b1000);
    add(0,0,0,8'h00,1, 0,8'h00,0,0, 3,2,3,4'b0000);
    // long line: 5 pixels; late flag once a non-EOL beat has pix >= 3
    add(1,0,0,8'h21,0, 1,8'h21,0,0, 3,2,3,4'b0000);
    add(1,0,0,8'h22,0, 1,8'h22,0,0, 3,2,3,4'b0000);
    add(1,0,0,8'h23,0, 1,8'h23,0,0, 3,2,3,4'b0000);
    add(1,0,0,8'h24,0, 1,8'h24,0,0, 3,2,3,4'b0100);
    add(1,0,1,8'h25,0, 1,8'h25,0,1, 5,2,3,4'b0100);
    add(0,0,0,8'h00,1, 0,8'h00,0,0, 5,2,3,4'b0000);
    // SOF after a single line, then a third line without SOF
    add(1,1,0,8'h31,0, 1,8'h31,1,0, 5,2,4,4'b0000);
    add(1,0,0,8'h32,0, 1,8'h32,0,0, 5,2,4,4'b0000);
    add(1,0,0,8'h33,0, 1,8'h33,0,0, 5,2,4,4'b0000);
    add(1,0,1,8'h34,0, 1,8'h34,0,1, 4,2,4,4'b0000);
    add(1,1,0,8'h35,0, 1,8'h35,1,0, 4,1,5,4'b0010);
    add(1,0,0,8'h36,0, 1,8'h36,0,0, 4,1,5,4'b0010);
    add(1,0,0,8'h37,0, 1,8'h37,0,0, 4,1,5,4'b0010);
    add(1,0,1,8'h38,0, 1,8'h38,0,1, 4,1,5,4'b0010);
    add(1,0,0,8'h39,0, 1,8'h39,0,0, 4,1,5,4'b0010);
    add(1,0,0,8'h3A,0, 1,8'h3A,0,0, 4,1,5,4'b0010);
    add(1,0,0,8'h3B,0, 1,8'h3B,0,0, 4,1,5,4'b0010);
    add(1,0,1,8'h3C,0, 1,8'h3C,0,1, 4,1,5,4'b0010);
    add(1,0,0,8'h3D,0, 1,8'h3D,0,0, 4,1,5,4'b0011);

    m_tready = 1'b1;
    foreach (vecs[i]) begin
      @(negedge aclk);
      drive(vecs[i].v, vecs[i].u, vecs[i].l, vecs[i].d);
      err_clr = vecs[i].clr;
      @(posedge aclk);
      #1;
      if (vecs[i].ev) begin
        act = {m_tvalid, m_tdata, m_tuser, m_tlast, line_len, frame_lines, frame_cnt, errs};
        req = {vecs[i].ev, vecs[i].ed, vecs[i].eu, vecs[i].el,
               vecs[i].len, vecs[i].fl, vecs[i].fc, vecs[i].err};
      end else begin
        act = {m_tvalid, line_len, frame_lines, frame_cnt, errs};
        req = {1'b0, vecs[i].len, vecs[i].fl, vecs[i].fc, vecs[i].err};
      end
      check($sformatf("vec[%0d]", i), act, req);
    end
    @(negedge aclk);
    drive(0, 0, 0, '0);
    err_clr = 1'b0;

    // ---- stall: skid fills, tready drops, drain in order ----
    do_reset();
    @(negedge aclk);
    m_tready = 1'b0;
    drive(1, 1, 0, 8'hA1);
    @(posedge aclk); #1;
    check("stall_first", {s_tready, m_tvalid, m_tdata}, {1'b1, 1'b1, 8'hA1});
    @(negedge aclk);
    drive(1, 0, 0, 8'hA2);
    @(posedge aclk); #1;
    check("stall_skid_full", {s_tready, m_tvalid, m_tdata}, {1'b0, 1'b1, 8'hA1});
    @(negedge aclk);
    drive(1, 0, 0, 8'hA3);
    @(posedge aclk); #1;
    check("stall_hold", {s_tready, m_tvalid, m_tdata}, {1'b0, 1'b1, 8'hA1});
    @(negedge aclk);
    m_tready = 1'b1;
    @(posedge aclk); #1;
    check("drain_skid", {s_tready, m_tvalid, m_tdata}, {1'b1, 1'b1, 8'hA2});
    @(posedge aclk); #1;
    check("drain_next", {m_tvalid, m_tdata}, {1'b1, 8'hA3});
    @(negedge aclk);
    m_tready = 1'b0;
    drive(1, 0, 0, 8'hA4);
    @(posedge aclk); #1;
    check("refill_skid", {s_tready, m_tvalid, m_tdata}, {1'b0, 1'b1, 8'hA3});

    // ---- reset mid-frame with both entries occupied ----
    @(negedge aclk);
    drive(0, 0, 0, '0);
    aresetn = 1'b0;
    #1;
    check("midframe_reset", {s_tready, m_tvalid, frame_cnt}, 64'd0);
    @(negedge aclk);
    aresetn  = 1'b1;
    m_tready = 1'b1;
    @(posedge aclk); #1;
    check("no_stale_output", {s_tready, m_tvalid}, {1'b1, 1'b0});
    @(negedge aclk);
    drive(1, 1, 0, 8'hA5);
    @(posedge aclk); #1;
    check("post_reset_beat", {m_tvalid, m_tuser, m_tdata}, {1'b1, 1'b1, 8'hA5});
    @(negedge aclk);
    drive(0, 0, 0, '0);

    // ---- random backpressure: 8 clean frames through the scoreboard ----
    do_reset();
    exp_q.delete();
    nxt = 0; rcvd = 0;
    acc_prev = 1'b0; stall_prev = 1'b0; prev_w = '0;
    for (int cyc = 0; cyc < 3000 && (nxt < 64 || exp_q.size() != 0); cyc++) begin
      @(negedge aclk);
      if (stall_prev)
        check("stall_stable", {m_tvalid, m_tuser, m_tlast, m_tdata}, prev_w);
      if (!(s_tvalid && !acc_prev)) begin
        if (nxt < 64 && $urandom_range(0, 3) != 0) begin
          {s_tuser, s_tlast, s_tdata} = beat_word(nxt);
          s_tvalid = 1'b1;
        end else begin
          s_tvalid = 1'b0;
        end
      end
      m_tready = 1'($urandom_range(0, 1));
      in_acc  = s_tvalid && s_tready;
      out_acc = m_tvalid && m_tready;
      if (out_acc) begin
        rcvd++;
        if (exp_q.size() == 0) check("sb_unexpected", {m_tuser, m_tlast, m_tdata}, 64'hDEAD);
        else check("sb_beat", {m_tuser, m_tlast, m_tdata}, exp_q.pop_front());
      end
      if (in_acc) begin
        exp_q.push_back({s_tuser, s_tlast, s_tdata});
        nxt++;
      end
      acc_prev   = in_acc;
      stall_prev = m_tvalid && !m_tready;
      prev_w     = {m_tvalid, m_tuser, m_tlast, m_tdata};
    end
    @(negedge aclk);
    drive(0, 0, 0, '0);
    m_tready = 1'b1;
    check("sb_rcvd", 64'(rcvd), 64'd64);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge aclk);
    #1;
    check("random_summary", {line_len, frame_lines, frame_cnt, errs},
          {12'd4, 12'd2, 16'd8, 4'b0000});

    // ---- beats before the first SOF ----
    do_reset();
    pre_cnt = 0; frm_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      drive(1, 0, 0, 8'hC1 + 8'(i));
      @(posedge aclk); #1;
      if (m_tvalid) pre_cnt++;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      if (i < 4) drive(1, i == 0, i == 3, 8'hD0 + 8'(i));
      else drive(0, 0, 0, '0);
      @(posedge aclk); #1;
      if (i == 0) check("sof_first_out", {m_tvalid, m_tuser, m_tdata}, {1'b1, 1'b1, 8'hD0});
      if (m_tvalid) frm_cnt++;
    end
`ifdef AXIS_VIDEO_MON_SOF_SYNC_EN
    check("presof_outputs", 64'(pre_cnt), 64'd0);
`else
    check("presof_outputs", 64'(pre_cnt), 64'd3);
`endif
    check("sof_frame_outputs", 64'(frm_cnt), 64'd4);
    check("sof_frame_cnt", {48'd0, frame_cnt}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
